// File: rtl/guess_game_gen.sv
// Reaction game: a lit LED sweeps across N positions and the player presses the matching key.
// Correct presses score; wrong presses cost a life until the game ends.
module guess_game_gen #(
    parameter int N        = 10,
    parameter int STEP_DIV = 4,
    parameter int SCORE_W  = 8,
    parameter int LIVES    = 3,
    localparam int LW      = $clog2(LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       G,
    input  logic               mode,
    output logic [N-1:0]       LED,
    output logic               hit,
    output logic               wrong,
    output logic [SCORE_W-1:0] score,
    output logic [LW-1:0]      lives_left,
    output logic               game_over
);

    localparam int PW = $clog2(N);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {RUN, HIT, MISS, OVER} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic               down_q, down_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       led_q, led_d;
    logic               hit_q, hit_d;
    logic               wrong_q, wrong_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic               over_q, over_d;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        down_d  = down_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (G == '0) begin
                    if (cnt_q == CW'(STEP_DIV - 1)) begin
                        cnt_d = '0;
                        // Mode is only looked at here, so a change lands on the next step.
                        if (!mode) begin
                            down_d = 1'b0;
                            pos_d  = (pos_q == PW'(N - 1)) ? '0 : pos_q + 1'b1;
                        end else if (!down_q) begin
                            if (pos_q == PW'(N - 1)) begin
                                down_d = 1'b1;
                                pos_d  = PW'(N - 2);
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                down_d = 1'b0;
                                pos_d  = PW'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (G == led_q) begin
                    state_d = HIT;
                    hit_d   = 1'b1;
                    score_d = sat_inc(score_q);
                end else begin
                    lives_d = lives_q - 1'b1;
                    state_d = (lives_q == LW'(1)) ? OVER : MISS;
                end
            end
            HIT, MISS: begin
                // Stay frozen until the key is released, so a press counts once.
                if (G == '0) begin
                    state_d = RUN;
                    pos_d   = '0;
                    down_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        led_d   = (state_d == OVER) ? '1 : ({{(N-1){1'b0}}, 1'b1} << pos_d);
        wrong_d = (state_d == MISS) || (state_d == OVER);
        over_d  = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pos_q   <= '0;
            down_q  <= 1'b0;
            cnt_q   <= '0;
            led_q   <= {{(N-1){1'b0}}, 1'b1};
            hit_q   <= 1'b0;
            wrong_q <= 1'b0;
            score_q <= '0;
            lives_q <= LW'(LIVES);
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            down_q  <= down_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            hit_q   <= hit_d;
            wrong_q <= wrong_d;
            score_q <= score_d;
            lives_q <= lives_d;
            over_q  <= over_d;
        end
    end

    assign LED        = led_q;
    assign hit        = hit_q;
    assign wrong      = wrong_q;
    assign score      = score_q;
    assign lives_left = lives_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_guess_game_gen.sv
// Bench for guess_game_gen: directed scenarios plus random play against a time-based model.
module tb_guess_game_gen;

    localparam int N  = 10;
    localparam int SD = 4;
    localparam int LW = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] G;
    logic         mode;
    logic [N-1:0] LED, LED2;
    logic         hit, hit2, wrong, wrong2, game_over, over2;
    logic [7:0]   score;
    logic [1:0]   score2;
    logic [LW-1:0] lives_left, lives2;

    guess_game_gen #(.N(N), .STEP_DIV(SD), .SCORE_W(8), .LIVES(3)) dut (
        .clk(clk), .reset(reset), .G(G), .mode(mode), .LED(LED), .hit(hit),
        .wrong(wrong), .score(score), .lives_left(lives_left), .game_over(game_over)
    );

    guess_game_gen #(.N(N), .STEP_DIV(SD), .SCORE_W(2), .LIVES(3)) dut_sat (
        .clk(clk), .reset(reset), .G(G), .mode(mode), .LED(LED2), .hit(hit2),
        .wrong(wrong2), .score(score2), .lives_left(lives2), .game_over(over2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase 0 run, 1 hit, 2 miss, 3 over; t counts released RUN cycles since restart.
    int           ph, t, sc, sc2, lives;
    bit           hexp, md;
    logic [N-1:0] frz;

    function automatic logic [N-1:0] sweep_led(input int tt, input bit bounce);
        int k, p;
        logic [N-1:0] r;
        k = tt / SD;
        if (!bounce) p = k % N;
        else begin
            k = k % (2 * N - 2);
            p = (k < N) ? k : 2 * N - 2 - k;
        end
        r = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] exp_led();
        if (ph == 3) return '1;
        if (ph == 0) return sweep_led(t, md);
        return frz;
    endfunction

    task automatic model_reset();
        ph = 0; t = 0; sc = 0; sc2 = 0; lives = 3; hexp = 0; md = mode; frz = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] g);
        hexp = 0;
        case (ph)
            0: begin
                if (g == '0) t++;
                else begin
                    frz = sweep_led(t, md);
                    if (g == frz) begin
                        ph = 1; hexp = 1;
                        if (sc < 255) sc++;
                        if (sc2 < 3) sc2++;
                    end else begin
                        lives--;
                        ph = (lives == 0) ? 3 : 2;
                    end
                end
            end
            1, 2: if (g == '0) begin ph = 0; t = 0; md = mode; end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("LED", 32'(LED), 32'(exp_led()));
        chk("hit", 32'(hit), 32'(hexp));
        chk("wrong", 32'(wrong), 32'(ph >= 2));
        chk("game_over", 32'(game_over), 32'(ph == 3));
        chk("score", 32'(score), 32'(sc));
        chk("lives", 32'(lives_left), 32'(lives));
        chk("LED_w2", 32'(LED2), 32'(exp_led()));
        chk("hit_w2", 32'(hit2), 32'(hexp));
        chk("wrong_w2", 32'(wrong2), 32'(ph >= 2));
        chk("over_w2", 32'(over2), 32'(ph == 3));
        chk("score_w2", 32'(score2), 32'(sc2));
        chk("lives_w2", 32'(lives2), 32'(lives));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(G);
        #1;
        check_all();
    endtask

    task automatic do_reset(input logic [N-1:0] g_hold);
        #2;
        G = g_hold;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_LED", 32'(LED), 32'h1);
        @(negedge clk);
        G = '0;
        reset = 1'b0;
    endtask

    initial begin
        G = '0;
        mode = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;

        // Wrap sweep
        repeat (45) step();

        // Bounce sweep
        mode = 1'b1;
        do_reset('0);
        repeat (4 * (2 * N - 2) + 8) step();

        // Correct guess held, then release
        mode = 1'b0;
        do_reset('0);
        repeat (12) step();
        G = 10'h008;
        repeat (5) step();
        G = '0;
        repeat (6) step();

        // Three wrong guesses lead to game over, then G and mode are ignored
        for (int i = 0; i < 3; i++) begin
            G = 10'h300;
            repeat (2) step();
            G = '0;
            step();
        end
        for (int i = 0; i < 10; i++) begin
            G = N'($urandom_range(0, (1 << N) - 1));
            mode = 1'($urandom_range(0, 1));
            step();
        end

        // Reset in OVER, then reset mid-press in MISS
        mode = 1'b0;
        do_reset(10'h155);
        repeat (6) step();
        G = 10'h300;
        repeat (2) step();
        do_reset(10'h300);
        repeat (9) step();

        // Score saturation on the narrow instance
        do_reset('0);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 9)) step();
            G = exp_led();
            repeat (2) step();
            G = '0;
            step();
        end

        // Random play
        for (int ep = 0; ep < 12; ep++) begin
            mode = 1'($urandom_range(0, 1));
            do_reset('0);
            for (int a = 0; a < 40; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6) begin
                    G = '0;
                    repeat ($urandom_range(1, 6)) step();
                end else begin
                    if (r < 8 && ph == 0) G = exp_led();
                    else G = N'($urandom_range(1, (1 << N) - 1));
                    repeat ($urandom_range(1, 3)) step();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
